// File: rtl/fft_r5_pkg.sv
// rtl/fft_r5_pkg.sv - shared constants and helpers for the radix-5 FFT stage
package fft_r5_pkg;

  localparam int DW_DEF = 32;
  localparam int RADIX = 5;
  // Legs 0..3 are buffered; leg 4 is taken straight from the input.
  localparam int LEGS_STORED = RADIX - 1;
  localparam int CW_DEF = 2 * DW_DEF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/r5_seg_mem.sv
// rtl/r5_seg_mem.sv - segment store: sync write, combinational read of all four buffered legs
module r5_seg_mem
  import fft_r5_pkg::*;
#(
  parameter int STRIDE = 5,
  parameter int CW = CW_DEF,
  parameter int AW = idx_w(STRIDE)
) (
  input  logic                             clk,
  input  logic                             we_i,
  input  logic [1:0]                       wseg_i,
  input  logic [AW-1:0]                    wpos_i,
  input  logic [CW-1:0]                    wdata_i,
  input  logic [AW-1:0]                    rpos_i,
  output logic [LEGS_STORED-1:0][CW-1:0]   rdata_o
);

  localparam int DEPTH = LEGS_STORED * STRIDE;
  localparam int MW = idx_w(DEPTH);

  logic [CW-1:0] mem_q [DEPTH];
  logic [MW-1:0] waddr;

  assign waddr = MW'(wseg_i) * MW'(STRIDE) + MW'(wpos_i);

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr] <= wdata_i;
    end
  end

  for (genvar j = 0; j < LEGS_STORED; j++) begin : g_leg
    logic [MW-1:0] raddr;
    assign raddr = MW'(j * STRIDE) + MW'(rpos_i);
    assign rdata_o[j] = mem_q[raddr];
  end

endmodule

// File: rtl/r5_stride_gather.sv
// rtl/r5_stride_gather.sv - regroups natural-order samples into STRIDE radix-5 tuples per frame
module r5_stride_gather
  import fft_r5_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int STRIDE = 5,
  localparam int KW = idx_w(STRIDE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_img,
  output logic          out_valid,
  output logic [DW-1:0] x0_re,
  output logic [DW-1:0] x1_re,
  output logic [DW-1:0] x2_re,
  output logic [DW-1:0] x3_re,
  output logic [DW-1:0] x4_re,
  output logic [DW-1:0] x0_img,
  output logic [DW-1:0] x1_img,
  output logic [DW-1:0] x2_img,
  output logic [DW-1:0] x3_img,
  output logic [DW-1:0] x4_img,
  output logic [KW-1:0] out_k,
  output logic          out_last
);

  localparam int CW = 2 * DW;
  localparam logic [KW-1:0] POS_MAX = KW'(STRIDE - 1);
  localparam logic [2:0] SEG_MAX = 3'(RADIX - 1);

  logic [KW-1:0] pos_q, pos_d;
  logic [2:0]    seg_q, seg_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [KW-1:0] out_k_q, out_k_d;
  logic [RADIX-1:0][DW-1:0] x_re_q, x_re_d;
  logic [RADIX-1:0][DW-1:0] x_im_q, x_im_d;

  logic pos_wrap, seg_last, emit, mem_we;
  logic [LEGS_STORED-1:0][CW-1:0] legs;

  assign pos_wrap = (pos_q == POS_MAX);
  assign seg_last = (seg_q == SEG_MAX);
  assign emit     = in_valid && seg_last;
  assign mem_we   = in_valid && !seg_last;

  r5_seg_mem #(
    .STRIDE (STRIDE),
    .CW     (CW),
    .AW     (KW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .wseg_i  (seg_q[1:0]),
    .wpos_i  (pos_q),
    .wdata_i ({a_re, a_img}),
    .rpos_i  (pos_q),
    .rdata_o (legs)
  );

  always_comb begin
    pos_d = pos_q;
    seg_d = seg_q;
    if (in_valid) begin
      if (pos_wrap) begin
        pos_d = '0;
        seg_d = seg_last ? 3'd0 : seg_q + 3'd1;
      end else begin
        pos_d = pos_q + KW'(1);
      end
    end
  end

  // Output registers only load on a seg-4 sample, so they hold between tuples.
  always_comb begin
    out_valid_d = emit;
    out_last_d  = out_last_q;
    out_k_d     = out_k_q;
    x_re_d      = x_re_q;
    x_im_d      = x_im_q;
    if (emit) begin
      out_last_d = pos_wrap;
      out_k_d    = pos_q;
      for (int j = 0; j < LEGS_STORED; j++) begin
        x_re_d[j] = legs[j][CW-1:DW];
        x_im_d[j] = legs[j][DW-1:0];
      end
      x_re_d[RADIX-1] = a_re;
      x_im_d[RADIX-1] = a_img;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q       <= '0;
      seg_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_k_q     <= '0;
      x_re_q      <= '0;
      x_im_q      <= '0;
    end else begin
      pos_q       <= pos_d;
      seg_q       <= seg_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_k_q     <= out_k_d;
      x_re_q      <= x_re_d;
      x_im_q      <= x_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_k     = out_k_q;
  assign x0_re  = x_re_q[0];
  assign x1_re  = x_re_q[1];
  assign x2_re  = x_re_q[2];
  assign x3_re  = x_re_q[3];
  assign x4_re  = x_re_q[4];
  assign x0_img = x_im_q[0];
  assign x1_img = x_im_q[1];
  assign x2_img = x_im_q[2];
  assign x3_img = x_im_q[3];
  assign x4_img = x_im_q[4];

endmodule

// File: tb/tb_r5_stride_gather.sv
// tb/tb_r5_stride_gather.sv - scoreboard bench for r5_stride_gather (STRIDE=5 and STRIDE=1 builds)
module tb_r5_stride_gather;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid, in_valid1;
  logic [31:0] a_re, a_img, b_re, b_img;
  logic        ov5, ol5, ov1, ol1;
  logic [2:0]  ok5;
  logic [0:0]  ok1;
  logic [31:0] r5_0, r5_1, r5_2, r5_3, r5_4, i5_0, i5_1, i5_2, i5_3, i5_4;
  logic [31:0] r1_0, r1_1, r1_2, r1_3, r1_4, i1_0, i1_1, i1_2, i1_3, i1_4;

  r5_stride_gather #(.DW(32), .STRIDE(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_re(a_re), .a_img(a_img),
    .out_valid(ov5),
    .x0_re(r5_0), .x1_re(r5_1), .x2_re(r5_2), .x3_re(r5_3), .x4_re(r5_4),
    .x0_img(i5_0), .x1_img(i5_1), .x2_img(i5_2), .x3_img(i5_3), .x4_img(i5_4),
    .out_k(ok5), .out_last(ol5)
  );

  r5_stride_gather #(.DW(32), .STRIDE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .a_re(b_re), .a_img(b_img),
    .out_valid(ov1),
    .x0_re(r1_0), .x1_re(r1_1), .x2_re(r1_2), .x3_re(r1_3), .x4_re(r1_4),
    .x0_img(i1_0), .x1_img(i1_1), .x2_img(i1_2), .x3_img(i1_3), .x4_img(i1_4),
    .out_k(ok1), .out_last(ol1)
  );

  logic [4:0][31:0] a5re, a5im, a1re, a1im;
  assign a5re = {r5_4, r5_3, r5_2, r5_1, r5_0};
  assign a5im = {i5_4, i5_3, i5_2, i5_1, i5_0};
  assign a1re = {r1_4, r1_3, r1_2, r1_1, r1_0};
  assign a1im = {i1_4, i1_3, i1_2, i1_1, i1_0};

  typedef struct packed {
    logic [4:0][31:0] re;
    logic [4:0][31:0] im;
    logic [2:0]       k;
    logic             last;
    logic [31:0]      due;
  } exp_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] f2off;
    bit          gapped;
    int          n;
    bit          extreme;
    int          exp_tuples;
  } vec_t;

  exp_t q5[$];
  exp_t q1[$];
  exp_t last5;
  int checks = 0;
  int failures = 0;
  int tup5 = 0;
  bit got_first = 0;
  logic [31:0] first_x0, first_x4;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Scoreboard for the STRIDE=5 instance, including hold checks between pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov5) begin
        if (q5.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL s5_unexpected_tuple actual=out_valid required=idle");
        end else begin
          exp_t e;
          e = q5.pop_front();
          chk("s5_latency", 160'(cyc), 160'(e.due));
          chk("s5_re", 160'(a5re), 160'(e.re));
          chk("s5_im", 160'(a5im), 160'(e.im));
          chk("s5_k", 160'(ok5), 160'(e.k));
          chk("s5_last", 160'(ol5), 160'(e.last));
          tup5++;
          last5 = e;
          if (!got_first) begin
            got_first = 1;
            first_x0 = r5_0;
            first_x4 = r5_4;
          end
        end
      end else begin
        chk("s5_hold_re", 160'(a5re), 160'(last5.re));
        chk("s5_hold_im", 160'(a5im), 160'(last5.im));
        chk("s5_hold_k_last", 160'({ok5, ol5}), 160'({last5.k, last5.last}));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL s1_unexpected_tuple actual=out_valid required=idle");
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("s1_latency", 160'(cyc), 160'(e.due));
        chk("s1_re", 160'(a1re), 160'(e.re));
        chk("s1_im", 160'(a1im), 160'(e.im));
        chk("s1_k_last", 160'({2'b00, ok1, ol1}), 160'({e.k, e.last}));
      end
    end
  end

  int m_pos, m_seg;
  logic [31:0] fbre [4][5];
  logic [31:0] fbim [4][5];

  task automatic send5(input logic [31:0] re, input logic [31:0] im);
    if (m_seg == 4) begin
      exp_t e;
      for (int j = 0; j < 4; j++) begin
        e.re[j] = fbre[j][m_pos];
        e.im[j] = fbim[j][m_pos];
      end
      e.re[4] = re;
      e.im[4] = im;
      e.k = 3'(m_pos);
      e.last = (m_pos == 4);
      e.due = 32'(cyc + 1);
      q5.push_back(e);
    end else begin
      fbre[m_seg][m_pos] = re;
      fbim[m_seg][m_pos] = im;
    end
    if (m_pos == 4) begin
      m_pos = 0;
      m_seg = (m_seg == 4) ? 0 : m_seg + 1;
    end else begin
      m_pos++;
    end
    a_re = re;
    a_img = im;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  int m1_cnt = 0;
  logic [31:0] fb1re [4];
  logic [31:0] fb1im [4];

  task automatic send1(input logic [31:0] re, input logic [31:0] im);
    if (m1_cnt == 4) begin
      exp_t e;
      for (int j = 0; j < 4; j++) begin
        e.re[j] = fb1re[j];
        e.im[j] = fb1im[j];
      end
      e.re[4] = re;
      e.im[4] = im;
      e.k = 3'd0;
      e.last = 1'b1;
      e.due = 32'(cyc + 1);
      q1.push_back(e);
      m1_cnt = 0;
    end else begin
      fb1re[m1_cnt] = re;
      fb1im[m1_cnt] = im;
      m1_cnt++;
    end
    b_re = re;
    b_img = im;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[4];

  initial begin
    tbl[0] = '{base: 32'd0, f2off: 32'd0,  gapped: 1'b0, n: 25, extreme: 1'b0, exp_tuples: 5};
    tbl[1] = '{base: 32'd0, f2off: 32'd0,  gapped: 1'b1, n: 25, extreme: 1'b0, exp_tuples: 5};
    tbl[2] = '{base: 32'd0, f2off: 32'd75, gapped: 1'b0, n: 50, extreme: 1'b0, exp_tuples: 10};
    tbl[3] = '{base: 32'd0, f2off: 32'd0,  gapped: 1'b0, n: 25, extreme: 1'b1, exp_tuples: 5};

    rst = 1'b1;
    in_valid = 1'b0;
    in_valid1 = 1'b0;
    a_re = '0; a_img = '0; b_re = '0; b_img = '0;
    m_pos = 0; m_seg = 0;
    last5 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s5_valid_last_k", 160'({ov5, ol5, ok5}), 160'(0));
    chk("rst_s5_re", 160'(a5re), 160'(0));
    chk("rst_s5_im", 160'(a5im), 160'(0));
    chk("rst_s1_all", 160'({ov1, ol1, ok1, a1re}), 160'(0));
    @(posedge clk);
    #1;

    for (int t = 0; t < 4; t++) begin
      tup5 = 0;
      for (int i = 0; i < tbl[t].n; i++) begin
        logic [31:0] v;
        v = tbl[t].base + 32'(i) + ((i >= 25) ? tbl[t].f2off : 32'd0);
        if (tbl[t].extreme) send5(32'h8000_0000, 32'h7FFF_FFFF);
        else send5(v, -v);
        if (tbl[t].gapped) idle(1);
      end
      idle(3);
      chk($sformatf("vec%0d_tuples", t), 160'(tup5), 160'(tbl[t].exp_tuples));
      chk($sformatf("vec%0d_drain", t), 160'(q5.size()), 160'(0));
    end

    // Mid-frame reset with a simultaneous valid that must be dropped.
    for (int i = 0; i < 13; i++) send5(32'(i), -32'(i));
    a_re = 32'hDEAD_BEEF;
    a_img = 32'h1234_5678;
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    m_pos = 0; m_seg = 0;
    q5.delete();
    last5 = '0;
    got_first = 0;
    @(negedge clk);
    chk("midrst_valid", 160'(ov5), 160'(0));
    chk("midrst_re", 160'(a5re), 160'(0));
    chk("midrst_im", 160'(a5im), 160'(0));
    chk("midrst_k_last", 160'({ok5, ol5}), 160'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 25; i++) send5(32'd200 + 32'(i), -(32'd200 + 32'(i)));
    idle(3);
    chk("midrst_first_x0", 160'(first_x0), 160'(200));
    chk("midrst_first_x4", 160'(first_x4), 160'(220));
    chk("midrst_drain", 160'(q5.size()), 160'(0));

    for (int i = 0; i < 10; i++) send1(32'(i), ~32'(i));
    idle(3);
    chk("s1_drain", 160'(q1.size()), 160'(0));
    chk("s1_model_tuples", 160'(m1_cnt), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
